timer_irq_dev: RTL

//  Memory-mapped countdown timer; the interrupt source feeding one HWint line of the CP0.
//  The CPU programs it via sw/lw through the bridge; on expiry it raises irq.
//  irq connects to CP0 HWint[2] and is masked there by SR.IM/IE/EXL.

---
 rtl/timer_irq_dev.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/timer_irq_dev.sv
// timer_irq_dev -- memory-mapped countdown timer and interrupt source.
// CTRL (EN/MODE/IM), PRESET and read-only COUNT registers, 4-state counting
// FSM with one-shot or auto-reload operation, registered irq output.
// Optional build macro: TIMER_PRESCALE_EN -- adds a 16-bit prescaler so COUNT
// decrements once every PRESCALE_DIV cycles instead of every cycle.
module timer_irq_dev #(
   parameter int unsigned PRESCALE_DIV = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        irq
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_CNT  = 2'd2,
      S_INT  = 2'd3
   } state_t;

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_PRESET = 2'd1;
   localparam logic [1:0] A_COUNT  = 2'd2;

   // Divider must fit the 16-bit prescale counter and be non-zero.
   if (PRESCALE_DIV < 1 || PRESCALE_DIV > 65535) begin : g_div_chk
      $error("timer_irq_dev: PRESCALE_DIV out of range 1..65535");
   end

   state_t      r_state;
   logic [3:0]  r_ctrl;
   logic [31:0] r_preset;
   logic [31:0] r_count;
   logic        r_flag;
   logic        r_irq;

   logic        w_ctrl_wr;
   logic        w_preset_wr;
   logic        w_auto;
   logic        w_tick;
   logic        w_expire;
   logic [3:0]  w_ctrl_nxt;
   logic        w_flag_nxt;

   assign w_ctrl_wr   = we && (addr == A_CTRL);
   assign w_preset_wr = we && (addr == A_PRESET);
   // Only MODE=01 reloads; 10 and 11 fall back to one-shot.
   assign w_auto      = (r_ctrl[2:1] == 2'b01);

`ifdef TIMER_PRESCALE_EN
   localparam logic [15:0] PS_TOP = 16'(PRESCALE_DIV - 1);
   logic [15:0] r_pre;
   assign w_tick = (r_pre == PS_TOP);
`else
   assign w_tick = 1'b1;
`endif

   // COUNT<=1 covers PRESET=0, which therefore expires like PRESET=1.
   assign w_expire = (r_state == S_CNT) && r_ctrl[0] && w_tick &&
                     (r_count <= 32'd1);

   // Next CTRL / irq_flag: FSM effects first, bus CTRL write overrides last.
   always_comb begin
      w_ctrl_nxt = r_ctrl;
      w_flag_nxt = r_flag;
      if (r_state == S_INT) begin
         if (w_auto) w_flag_nxt = 1'b0;
         else        w_ctrl_nxt[0] = 1'b0;
      end
      if (w_expire) w_flag_nxt = 1'b1;
      if (w_ctrl_wr) begin
         w_ctrl_nxt = din[3:0];
         w_flag_nxt = 1'b0;
      end
   end

   // Counting FSM plus register file; irq registered from next flag and IM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_ctrl   <= '0;
         r_preset <= '0;
         r_count  <= '0;
         r_flag   <= 1'b0;
         r_irq    <= 1'b0;
`ifdef TIMER_PRESCALE_EN
         r_pre    <= '0;
`endif
      end else begin
         r_ctrl <= w_ctrl_nxt;
         r_flag <= w_flag_nxt;
         r_irq  <= w_flag_nxt & w_ctrl_nxt[3];
         if (w_preset_wr) r_preset <= din;
         case (r_state)
            S_IDLE: begin
               if (r_ctrl[0]) r_state <= S_LOAD;
            end
            S_LOAD: begin
               r_count <= r_preset;
`ifdef TIMER_PRESCALE_EN
               r_pre   <= '0;
`endif
               r_state <= S_CNT;
            end
            S_CNT: begin
               // Disable is honoured every cycle, independent of the prescaler.
               if (!r_ctrl[0]) begin
                  r_state <= S_IDLE;
               end else begin
`ifdef TIMER_PRESCALE_EN
                  if (w_tick) r_pre <= '0;
                  else        r_pre <= r_pre + 16'd1;
`endif
                  if (w_tick) begin
                     if (r_count > 32'd1) begin
                        r_count <= r_count - 32'd1;
                     end else begin
                        r_count <= '0;
                        r_state <= S_INT;
                     end
                  end
               end
            end
            S_INT: begin
               if (w_auto) r_state <= S_LOAD;
               else        r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Read mux; reserved offset and CTRL upper bits read as zero.
   always_comb begin
      dout = '0;
      case (addr)
         A_CTRL:   dout = {28'd0, r_ctrl};
         A_PRESET: dout = r_preset;
         A_COUNT:  dout = r_count;
         default:  dout = '0;
      endcase
   end

   assign irq = r_irq;

endmodule
